// File: rtl/uart_receive_if.sv
// Byte handshake between the UART receiver (master) and its consumer (slave).
interface uart_receive_if;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ack;

    modport master (output data, output data_valid, input data_ack);
    modport slave  (input data, input data_valid, output data_ack);
endinterface

// File: rtl/uart_receive.sv
// UART receiver, 8N1, LSB first, idle-high line, mid-bit sampling.
// Optional feature macro: RX_MAJORITY_EN (2-of-3 vote around mid-bit, +1 cycle latency).
module uart_receive #(
    parameter int unsigned CLKS_PER_BIT = 10000,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic           Clk_100M,
    input  logic           Rst_n,
    input  logic           UART_Rx,
    uart_receive_if.master rx_if,
    output logic           busy,
    output logic           frame_err,
    output logic           overrun
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
`ifdef RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] MID_M1 = CNT_W'(CLKS_PER_BIT / 2 - 2);
    localparam logic [CNT_W-1:0] SAMP   = CNT_W'(CLKS_PER_BIT / 2);
`else
    localparam logic [CNT_W-1:0] SAMP   = MID;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic                   dv_q, dv_d;
    logic                   fe_q, fe_d;
    logic                   ov_q, ov_d;
    logic                   busy_q;
    logic                   rx_s;
    logic                   sample_c;

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Metastability synchroniser; preset to idle-high so reset never looks like a start bit.
    always_ff @(posedge Clk_100M or negedge Rst_n) begin
        if (!Rst_n) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], UART_Rx};
    end

`ifdef RX_MAJORITY_EN
    logic [1:0] vote_q;

    // Capture the two samples preceding the decision point; the third is live rx_s.
    always_ff @(posedge Clk_100M or negedge Rst_n) begin
        if (!Rst_n) begin
            vote_q <= 2'b11;
        end else begin
            if (cnt_q == MID_M1) vote_q[0] <= rx_s;
            if (cnt_q == MID)    vote_q[1] <= rx_s;
        end
    end

    // 2-of-3 majority of samples at MID-1, MID, MID+1.
    always_comb begin
        sample_c = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
    end
`else
    // Single sample at mid-bit.
    always_comb begin
        sample_c = rx_s;
    end
`endif

    // State, datapath and output registers.
    always_ff @(posedge Clk_100M or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    // Next-state logic; cnt tracks position within the current bit, detection cycle = 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        dv_d    = dv_q & ~rx_if.data_ack;
        fe_d    = 1'b0;
        ov_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_START: begin
                if (cnt_q == SAMP) begin
                    if (sample_c) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end
                end
            end
            ST_DATA: begin
                if (cnt_q == SAMP) begin
                    shift_d[idx_q] = sample_c;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_q == SAMP) begin
                    if (sample_c) begin
                        data_d  = shift_q;
                        dv_d    = 1'b1;
                        ov_d    = dv_q & ~rx_if.data_ack;
                        state_d = ST_IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                cnt_d = '0;
                if (rx_s) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rx_if.data       = data_q;
    assign rx_if.data_valid = dv_q;
    assign busy             = busy_q;
    assign frame_err        = fe_q;
    assign overrun          = ov_q;
endmodule
